// File: rtl/adaptive_thresh_bin_if.sv
// Stream bundle for adaptive_thresh_bin: raw gray writes, mean requests, binary results.
interface adaptive_thresh_bin_if;
  logic        gray_valid;
  logic [7:0]  gray;
  logic        mean_valid;
  logic [7:0]  mean_in;
  logic [31:0] center_row;
  logic [31:0] center_col;
  logic        bin_valid;
  logic [7:0]  bin_out;
  logic [31:0] out_row;
  logic [31:0] out_col;
  logic        miss_err;

  modport master (
    output gray_valid, gray, mean_valid, mean_in, center_row, center_col,
    input  bin_valid, bin_out, out_row, out_col, miss_err
  );

  modport slave (
    input  gray_valid, gray, mean_valid, mean_in, center_row, center_col,
    output bin_valid, bin_out, out_row, out_col, miss_err
  );
endinterface

// File: rtl/adaptive_thresh_bin.sv
// Binarises each centre pixel against its 9x9 local mean, using a private ring
// buffer of the raw gray stream; fixed 2-cycle latency, one request per cycle.
module adaptive_thresh_bin #(
  parameter int       IMAGE_WIDTH = 320,
  parameter int       LINES       = 8,
  parameter logic [7:0] OFFSET_C  = 8'd5,
  parameter bit       INVERT      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  adaptive_thresh_bin_if.slave bus
);
  localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int ROW_W = $clog2(LINES);

  logic [7:0]       mem [LINES][IMAGE_WIDTH];
  logic [31:0]      wr_row;
  logic [COL_W-1:0] wr_col;

  logic [ROW_W-1:0] wr_slot, rd_slot;
  logic [COL_W-1:0] rd_col;
  logic             written, not_evicted, avail;

  logic             v1;
  logic [7:0]       pix1, mean1;
  logic [31:0]      row1, col1;
  logic             avail1;

  logic [7:0]       thr;
  logic             hit;
  logic [7:0]       bin_next;

  assign wr_slot = wr_row[ROW_W-1:0];
  assign rd_slot = bus.center_row[ROW_W-1:0];
  assign rd_col  = bus.center_col[COL_W-1:0];

  // Evaluated on pre-write state: the slot being written this cycle counts as unwritten.
  always_comb begin
    written     = (bus.center_row < wr_row) ||
                  ((bus.center_row == wr_row) && (bus.center_col < 32'(wr_col)));
    not_evicted = (bus.center_row + 32'(LINES)) > wr_row;
    avail       = written && not_evicted;
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.gray_valid) begin
      mem[wr_slot][wr_col] <= bus.gray;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_row <= '0;
      wr_col <= '0;
    end else if (bus.gray_valid) begin
      if (wr_col == COL_W'(IMAGE_WIDTH - 1)) begin
        wr_col <= '0;
        wr_row <= wr_row + 32'd1;
      end else begin
        wr_col <= wr_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else begin
      v1 <= bus.mean_valid;
    end
    pix1   <= mem[rd_slot][rd_col];
    mean1  <= bus.mean_in;
    row1   <= bus.center_row;
    col1   <= bus.center_col;
    avail1 <= avail;
  end

  always_comb begin
    thr      = (mean1 > OFFSET_C) ? (mean1 - OFFSET_C) : '0;
    hit      = pix1 > thr;
    bin_next = (avail1 && (hit ^ INVERT)) ? 8'hFF : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.bin_valid <= 1'b0;
      bus.bin_out   <= '0;
      bus.out_row   <= '0;
      bus.out_col   <= '0;
      bus.miss_err  <= 1'b0;
    end else begin
      bus.bin_valid <= v1;
      if (v1) begin
        bus.bin_out <= bin_next;
        bus.out_row <= row1;
        bus.out_col <= col1;
        if (!avail1) begin
          bus.miss_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_adaptive_thresh_bin.sv
// Self-checking bench for adaptive_thresh_bin: normal and inverted instances share
// one stimulus stream and are checked against a frame-level reference model.
module tb_adaptive_thresh_bin;
  localparam int W = 16;
  localparam int L = 8;
  localparam int C = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adaptive_thresh_bin_if ifc ();
  adaptive_thresh_bin_if ifi ();

  assign ifi.gray_valid = ifc.gray_valid;
  assign ifi.gray       = ifc.gray;
  assign ifi.mean_valid = ifc.mean_valid;
  assign ifi.mean_in    = ifc.mean_in;
  assign ifi.center_row = ifc.center_row;
  assign ifi.center_col = ifc.center_col;

  adaptive_thresh_bin #(.IMAGE_WIDTH(W), .LINES(L), .OFFSET_C(8'd5), .INVERT(1'b0))
    dut (.clk(clk), .rst(rst), .bus(ifc));
  adaptive_thresh_bin #(.IMAGE_WIDTH(W), .LINES(L), .OFFSET_C(8'd5), .INVERT(1'b1))
    dut_inv (.clk(clk), .rst(rst), .bus(ifi));

  typedef struct {
    int          cyc;
    logic        v, v_i;
    logic [31:0] row, col;
    logic [7:0]  bin, bin_i;
    logic        miss, miss_i;
  } obs_t;

  typedef struct {
    int          due;
    logic [31:0] row, col;
    logic [7:0]  bin, bin_i;
    logic        miss;
  } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];
  obs_t o;
  exp_t e;
  int cyc = 0;
  int checks = 0;
  int passes = 0;

  // Reference model: the whole frame as a linear pixel array indexed row*W+col.
  int unsigned     wcount;
  logic [7:0]      img [int];
  bit              m_miss;

  function automatic bit m_avail(int unsigned r, int unsigned c);
    int unsigned lin;
    lin = r * W + c;
    return (lin < wcount) && (r + L > wcount / W);
  endfunction

  task automatic model_reset();
    wcount = 0;
    img.delete();
    m_miss = 1'b0;
    exp_q.delete();
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (ifc.bin_valid || ifi.bin_valid)
      obs_q.push_back('{cyc, ifc.bin_valid, ifi.bin_valid, ifc.out_row, ifc.out_col,
                        ifc.bin_out, ifi.bin_out, ifc.miss_err, ifi.miss_err});
  endtask

  task automatic drive(bit gv, logic [7:0] g, bit mv, logic [7:0] m,
                       int unsigned r, int unsigned c);
    bit         av, hit;
    int         thr;
    logic [7:0] pix;
    ifc.gray_valid = gv;
    ifc.gray       = g;
    ifc.mean_valid = mv;
    ifc.mean_in    = m;
    ifc.center_row = r;
    ifc.center_col = c;
    if (mv) begin
      av  = m_avail(r, c);
      thr = (int'(m) > C) ? int'(m) - C : 0;
      pix = av ? img[int'(r * W + c)] : 8'd0;
      hit = int'(pix) > thr;
      if (!av) m_miss = 1'b1;
      exp_q.push_back('{cyc + 2, r, c, (av && hit) ? 8'd255 : 8'd0,
                        (av && !hit) ? 8'd255 : 8'd0, m_miss});
    end
    if (gv) begin
      img[int'(wcount)] = g;
      wcount++;
    end
    cycle();
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 8'd0, 1'b0, 8'd0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if ({ifc.bin_valid, ifc.bin_out, ifc.out_row, ifc.out_col, ifc.miss_err} !== 74'b0)
      $display("FAIL reset_outputs got v=%b bin=%0d row=%0d col=%0d miss=%b want all 0",
               ifc.bin_valid, ifc.bin_out, ifc.out_row, ifc.out_col, ifc.miss_err);
    else passes++;
    checks++;
    if ({ifi.bin_valid, ifi.bin_out, ifi.out_row, ifi.out_col, ifi.miss_err} !== 74'b0)
      $display("FAIL reset_outputs_inv got v=%b bin=%0d row=%0d col=%0d miss=%b want all 0",
               ifi.bin_valid, ifi.bin_out, ifi.out_row, ifi.out_col, ifi.miss_err);
    else passes++;
    rst = 1'b0;
    model_reset();
    obs_q.delete();
  endtask

  task automatic test_threshold();
    logic [7:0] v;
    // Rows 0-1 random, rows 2-5 constant 100 with a few directed pixels.
    for (int i = 0; i < 6 * W; i++) begin
      v = (i < 2 * W) ? 8'($urandom_range(0, 255)) : 8'd100;
      if (i == 2 * W + 3) v = 8'd90;
      if (i == 2 * W + 4) v = 8'd96;
      if (i == 3 * W + 0) v = 8'd0;
      if (i == 3 * W + 1) v = 8'd1;
      drive(1'b1, v, 1'b0, 8'd0, 0, 0);
    end
    drive(1'b0, 8'd0, 1'b1, 8'd100, 5, 5);
    idle(1);
    drive(1'b0, 8'd0, 1'b1, 8'd100, 2, 3);
    drive(1'b0, 8'd0, 1'b1, 8'd100, 2, 4);
    drive(1'b0, 8'd0, 1'b1, 8'd3, 3, 0);
    drive(1'b0, 8'd0, 1'b1, 8'd3, 3, 1);
    drive(1'b0, 8'd0, 1'b1, 8'd5, 3, 0);
    drive(1'b0, 8'd0, 1'b1, 8'd6, 3, 1);
    for (int i = 0; i < 6; i++)
      drive(1'b0, 8'd0, 1'b1, 8'($urandom_range(0, 255)),
            $urandom_range(0, 5), $urandom_range(0, W - 1));
    idle(3);
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL thr_count got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.cyc !== e.due || o.v !== 1'b1 || o.v_i !== 1'b1 || o.row !== e.row ||
          o.col !== e.col || o.bin !== e.bin || o.bin_i !== e.bin_i ||
          o.miss !== e.miss || o.miss_i !== e.miss)
        $display("FAIL thr_result got cyc=%0d v=%b/%b rc=%0d,%0d bin=%0d/%0d miss=%b/%b want cyc=%0d rc=%0d,%0d bin=%0d/%0d miss=%b",
                 o.cyc, o.v, o.v_i, o.row, o.col, o.bin, o.bin_i, o.miss, o.miss_i,
                 e.due, e.row, e.col, e.bin, e.bin_i, e.miss);
      else passes++;
    end
    obs_q.delete();
    exp_q.delete();
    checks++;
    if (ifc.miss_err !== 1'b0 || ifi.miss_err !== 1'b0)
      $display("FAIL thr_no_miss got %b/%b want 0", ifc.miss_err, ifi.miss_err);
    else passes++;
  endtask

  task automatic test_eviction();
    for (int i = 0; i < 4 * W; i++)
      drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 8'd0, 0, 0);
    drive(1'b0, 8'd0, 1'b1, 8'($urandom_range(0, 255)), 1, 7);
    drive(1'b0, 8'd0, 1'b1, 8'($urandom_range(0, 255)), 5, 9);
    drive(1'b0, 8'd0, 1'b1, 8'd100, 2, 0);
    drive(1'b0, 8'd0, 1'b1, 8'($urandom_range(0, 255)), 3, W - 1);
    idle(3);
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL evict_count got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.cyc !== e.due || o.v !== 1'b1 || o.v_i !== 1'b1 || o.row !== e.row ||
          o.col !== e.col || o.bin !== e.bin || o.bin_i !== e.bin_i ||
          o.miss !== e.miss || o.miss_i !== e.miss)
        $display("FAIL evict_result got cyc=%0d v=%b/%b rc=%0d,%0d bin=%0d/%0d miss=%b/%b want cyc=%0d rc=%0d,%0d bin=%0d/%0d miss=%b",
                 o.cyc, o.v, o.v_i, o.row, o.col, o.bin, o.bin_i, o.miss, o.miss_i,
                 e.due, e.row, e.col, e.bin, e.bin_i, e.miss);
      else passes++;
    end
    obs_q.delete();
    exp_q.delete();
    idle(4);
    checks++;
    if (ifc.miss_err !== 1'b1 || ifi.miss_err !== 1'b1)
      $display("FAIL evict_sticky got %b/%b want 1", ifc.miss_err, ifi.miss_err);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int unsigned r, c;
    for (int i = 0; i < 16; i++) begin
      if (i == 5 || i == 11) begin
        r = wcount / W;
        c = wcount % W;
      end else begin
        r = wcount / W - 9 + $urandom_range(0, 9);
        c = $urandom_range(0, W - 1);
      end
      drive(1'b1, 8'($urandom_range(0, 255)), 1'b1, 8'($urandom_range(0, 255)), r, c);
    end
    idle(3);
    checks++;
    if (obs_q.size() != 16 || exp_q.size() != 16)
      $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.cyc !== e.due || o.v !== 1'b1 || o.v_i !== 1'b1 || o.row !== e.row ||
          o.col !== e.col || o.bin !== e.bin || o.bin_i !== e.bin_i ||
          o.miss !== e.miss || o.miss_i !== e.miss)
        $display("FAIL b2b_result got cyc=%0d v=%b/%b rc=%0d,%0d bin=%0d/%0d miss=%b/%b want cyc=%0d rc=%0d,%0d bin=%0d/%0d miss=%b",
                 o.cyc, o.v, o.v_i, o.row, o.col, o.bin, o.bin_i, o.miss, o.miss_i,
                 e.due, e.row, e.col, e.bin, e.bin_i, e.miss);
      else passes++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    drive(1'b0, 8'd0, 1'b1, 8'd100, wcount / W - 2, 3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    model_reset();
    idle(3);
    checks++;
    if (obs_q.size() != 0)
      $display("FAIL rst_drop got %0d results want 0", obs_q.size());
    else passes++;
    checks++;
    if ({ifc.bin_valid, ifc.bin_out, ifc.out_row, ifc.out_col, ifc.miss_err,
         ifi.bin_valid, ifi.bin_out, ifi.out_row, ifi.out_col, ifi.miss_err} !== 148'b0)
      $display("FAIL rst_outputs got bin=%0d/%0d row=%0d col=%0d miss=%b/%b want all 0",
               ifc.bin_out, ifi.bin_out, ifc.out_row, ifc.out_col, ifc.miss_err, ifi.miss_err);
    else passes++;
    obs_q.delete();
    drive(1'b1, 8'd200, 1'b0, 8'd0, 0, 0);
    drive(1'b1, 8'd50, 1'b1, 8'd100, 0, 1);
    drive(1'b0, 8'd0, 1'b1, 8'd100, 0, 0);
    drive(1'b0, 8'd0, 1'b1, 8'd100, 0, 1);
    idle(3);
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL restart_count got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.cyc !== e.due || o.v !== 1'b1 || o.v_i !== 1'b1 || o.row !== e.row ||
          o.col !== e.col || o.bin !== e.bin || o.bin_i !== e.bin_i ||
          o.miss !== e.miss || o.miss_i !== e.miss)
        $display("FAIL restart_result got cyc=%0d v=%b/%b rc=%0d,%0d bin=%0d/%0d miss=%b/%b want cyc=%0d rc=%0d,%0d bin=%0d/%0d miss=%b",
                 o.cyc, o.v, o.v_i, o.row, o.col, o.bin, o.bin_i, o.miss, o.miss_i,
                 e.due, e.row, e.col, e.bin, e.bin_i, e.miss);
      else passes++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    ifc.gray_valid = 1'b0;
    ifc.gray       = '0;
    ifc.mean_valid = 1'b0;
    ifc.mean_in    = '0;
    ifc.center_row = '0;
    ifc.center_col = '0;
    model_reset();
    test_reset();
    test_threshold();
    test_eviction();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/adaptive_thresh_bin.md
Name: adaptive_thresh_bin

Overview:
- Downstream stage of the 9x9 mean filter.
- Binarises each centre pixel against its local mean: output is 255 when pixel > mean − OFFSET_C, else 0. Polarity is selectable.
- Keeps its own ring buffer of the raw gray stream. Each incoming mean result is paired with the raw pixel at the reported (center_row, center_col).
- Output feeds the binary-image consumers (morphology / contour stages).

Parameters:
- IMAGE_WIDTH, 320, pixels per row; column address width is clog2(IMAGE_WIDTH), minimum 1.
- LINES, 8, raw rows held in the ring buffer; must be a power of 2 and ≥ 8.
- OFFSET_C, 5, unsigned 8-bit constant subtracted from the mean.
- INVERT, 0, when 1 the output polarity is swapped (255 ↔ 0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- gray_valid  in  1  raw pixel strobe, raster order
- gray  in  8  raw pixel
- mean_valid  in  1  mean result strobe
- mean_in  in  8  9x9 local mean
- center_row  in  32  row index of the pixel the mean belongs to
- center_col  in  32  column index of that pixel (< IMAGE_WIDTH)
- bin_valid  out  1  binary result strobe
- bin_out  out  8  0 or 255
- out_row  out  32  center_row echoed with the result
- out_col  out  32  center_col echoed with the result
- miss_err  out  1  sticky flag: a requested pixel was not in the buffer

Behaviour:
- Reset: bin_valid=0, bin_out=0, out_row=0, out_col=0, miss_err=0, wr_row=0, wr_col=0, pipeline valids cleared. Buffer contents are not cleared.
- Write side, per gray_valid:
  - store gray at slot [wr_row mod LINES][wr_col].
  - if wr_col == IMAGE_WIDTH−1: wr_col ← 0 and wr_row ← wr_row+1; otherwise wr_col ← wr_col+1.
  - wr_row is 32-bit and wraps naturally.
- Availability of (r, c), evaluated on the pre-write state of the same cycle:
  - written: r < wr_row, or (r == wr_row and c < wr_col).
  - not evicted: r + LINES > wr_row.
  - available = written AND not evicted.
- Read pipeline, fixed latency 2, fully pipelined: one mean_valid accepted per cycle, no backpressure.
  - Stage 1 (cycle of mean_valid): register the buffer read at [r mod LINES][c], mean_in, r, c and the available flag.
  - Stage 2: compute and drive outputs on the next edge.
  - bin_valid is high for exactly one cycle per mean_valid, two cycles later.
- Arithmetic in stage 2:
  - thr = mean − OFFSET_C, saturating at 0 (mean < OFFSET_C gives thr = 0).
  - hit = pix > thr (strict); bin_out = (hit XOR INVERT) ? 255 : 0.
- Miss handling: if the pixel was not available, bin_out=0 regardless of INVERT, bin_valid still asserts, and miss_err sets and stays set until rst.
- out_row / out_col: updated only when bin_valid asserts; hold otherwise.
- Simultaneous events:
  - gray_valid and mean_valid in the same cycle are independent; the read sees pre-write buffer contents.
  - Reading the address being written in that cycle is by definition "not written", so it is a miss.
- Reset mid-frame: in-flight results are dropped (no bin_valid after rst). After rst release, the next gray pixel is treated as row 0, col 0.
- Row counter wrap: availability compares use 32-bit modular arithmetic consistently. Wrap is not exercised in practice.

Test Plan:
- Constant frame of 100, mean_in=100, IMAGE_WIDTH=16, request (5,5) → bin_valid exactly 2 cycles after mean_valid, bin_out=255 (100 > 95), out_row=5, out_col=5, miss_err=0.
- Pixel 90, mean 100 → 0. Pixel 96, mean 100 → 255. Repeat with INVERT=1 → 255, then 0.
- Saturation: mean 3, OFFSET_C=5, pixel 0 → thr=0, 0 > 0 false → bin_out=0. Same mean, pixel 1 → 255.
- Eviction: IMAGE_WIDTH=16, LINES=8; stream 10 full rows, then request row 1 → bin_out=0, miss_err=1 and stays 1. A subsequent valid request in row 5 → correct result; miss_err still 1.
- Back-to-back means for 16 consecutive cycles interleaved with gray writes → 16 consecutive bin_valid pulses, in order, each with matching out_row/out_col. Request of the not-yet-written address (wr_row, wr_col) → miss.
- Assert rst for 1 cycle between a mean_valid and its expected output → no bin_valid. All outputs 0. Writes restart at row 0, col 0.
